// File: rtl/chaos_pkg.sv
// Shared types and defaults for the chaotic S-box byte generator.
// Holds the map width, gain, reinit state, retry bound and FSM state encoding.
package chaos_pkg;

  localparam int FRAC_BITS = 16;
  localparam int BYTE_W    = 8;
  localparam int NUM_SYM   = 256;
  localparam int CNT_W     = 9;

  localparam logic [FRAC_BITS+1:0] R_FIX_DEF       = 18'h3FD71;
  localparam logic [FRAC_BITS-1:0] SEED_REINIT_DEF = 16'h4F1B;
  localparam int                   MAX_TRIES_DEF   = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_MUL2,
    S_CHK,
    S_FALLBK,
    S_EMIT,
    S_DONE
  } state_t;

  // Lowest-index clear bit of the used-byte map.
  function automatic logic [BYTE_W-1:0] first_clear(
    input logic [NUM_SYM-1:0] map
  );
    logic [BYTE_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SYM - 1; i >= 0; i--) begin
      if (!map[i]) idx = BYTE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/logistic_map_step.sv
// Two-register fixed-point logistic map step x' = R*x*(1-x).
// Ports: clk, rst, load (take seed), mul1/mul2 (advance), seed, top_byte.
module logistic_map_step
  import chaos_pkg::*;
#(
  parameter int               FRAC        = FRAC_BITS,
  parameter logic [FRAC+1:0]  R_FIX       = R_FIX_DEF,
  parameter logic [FRAC-1:0]  SEED_REINIT = SEED_REINIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              mul1,
  input  logic              mul2,
  input  logic [FRAC-1:0]   seed,
  output logic [BYTE_W-1:0] top_byte
);

  localparam int P1_W = 2 * FRAC;
  localparam int P2_W = 2 * FRAC + 2;
  localparam logic [FRAC:0] ONE = {1'b1, {FRAC{1'b0}}};

  logic [FRAC-1:0] x;
  logic [FRAC-1:0] t;
  logic [FRAC-1:0] t_nx;
  logic [FRAC-1:0] x_sat;
  logic [FRAC-1:0] x_nx;
  logic [FRAC-1:0] seed_eff;
  logic [FRAC:0]   one_minus_x;
  logic [P1_W-1:0] prod1;
  logic [P2_W-1:0] prod2;
  logic [FRAC+1:0] x_wide;

  // x*(1-x) peaks at 1/4, so the product always fits 2*FRAC bits.
  assign one_minus_x = ONE - {1'b0, x};
  assign prod1       = P1_W'(x) * P1_W'(one_minus_x);
  assign t_nx        = FRAC'(prod1 >> FRAC);

  assign prod2  = P2_W'(R_FIX) * P2_W'(t);
  assign x_wide = (FRAC + 2)'(prod2 >> FRAC);

  // Clamp below 1.0; a zero state would lock the map at 0.
  assign x_sat = (|x_wide[FRAC+1:FRAC]) ? '1 : x_wide[FRAC-1:0];
  assign x_nx  = (x_sat == '0) ? SEED_REINIT : x_sat;

  assign seed_eff = (seed == '0) ? SEED_REINIT : seed;
  assign top_byte = x[FRAC-1 -: BYTE_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      t <= '0;
    end else if (load) begin
      x <= seed_eff;
    end else if (mul1) begin
      t <= t_nx;
    end else if (mul2) begin
      x <= x_nx;
    end
  end

endmodule

// File: rtl/chaos_sbox_gen.sv
// Emits a 256-byte permutation drawn from a logistic-map orbit.
// Ports: clk, rst, start, seed, out_ready / out_valid, out_data, busy, done,
// fallback_cnt (bytes of this run taken from the lowest unused slot).
module chaos_sbox_gen
  import chaos_pkg::*;
#(
  parameter int               FRAC        = FRAC_BITS,
  parameter logic [FRAC+1:0]  R_FIX       = R_FIX_DEF,
  parameter logic [FRAC-1:0]  SEED_REINIT = SEED_REINIT_DEF,
  parameter int               MAX_TRIES   = MAX_TRIES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FRAC-1:0]   seed,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  fallback_cnt
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_SYM);

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_inc;
  logic [TRY_W-1:0]   tries;
  logic [TRY_W-1:0]   tries_inc;
  logic [NUM_SYM-1:0] used_map;
  logic [BYTE_W-1:0]  cand;
  logic [BYTE_W-1:0]  map_byte;

  logic idle_like;
  logic start_acc;
  logic cand_used;
  logic last_try;
  logic xfer;
  logic step_load;
  logic step_mul1;
  logic step_mul2;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign start_acc = start && idle_like;
  assign cand_used = used_map[map_byte];
  assign tries_inc = tries + TRY_W'(1);
  assign last_try  = (tries_inc == TRY_LAST);
  assign count_inc = count + CNT_W'(1);
  assign xfer      = (state == S_EMIT) && out_ready;
  assign out_data  = cand;

  logistic_map_step #(
    .FRAC        (FRAC),
    .R_FIX       (R_FIX),
    .SEED_REINIT (SEED_REINIT)
  ) u_step (
    .clk      (clk),
    .rst      (rst),
    .load     (step_load),
    .mul1     (step_mul1),
    .mul2     (step_mul2),
    .seed     (seed),
    .top_byte (map_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nx = S_MUL1;
      end
      S_MUL1:   state_nx = S_MUL2;
      S_MUL2:   state_nx = S_CHK;
      S_CHK: begin
        if (!cand_used)    state_nx = S_EMIT;
        else if (last_try) state_nx = S_FALLBK;
        else               state_nx = S_MUL1;
      end
      S_FALLBK: state_nx = S_EMIT;
      S_EMIT: begin
        if (out_ready) begin
          state_nx = (count_inc == CNT_FULL) ? S_DONE : S_MUL1;
        end
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == S_EMIT);
    busy      = !idle_like;
    done      = (state == S_DONE);
    step_load = start_acc;
    step_mul1 = (state == S_MUL1);
    step_mul2 = (state == S_MUL2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      tries        <= '0;
      used_map     <= '0;
      cand         <= '0;
      fallback_cnt <= '0;
    end else if (start_acc) begin
      count        <= '0;
      tries        <= '0;
      used_map     <= '0;
      fallback_cnt <= '0;
    end else begin
      unique case (1'b1)
        (state == S_CHK): begin
          if (!cand_used) begin
            cand  <= map_byte;
            tries <= '0;
          end else begin
            tries <= tries_inc;
          end
        end
        // Map state is left alone; the orbit resumes from the current x.
        (state == S_FALLBK): begin
          cand         <= first_clear(used_map);
          fallback_cnt <= fallback_cnt + CNT_W'(1);
          tries        <= '0;
        end
        xfer: begin
          used_map[cand] <= 1'b1;
          count          <= count_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
